// File: rtl/pmod_als_spi_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pmod_als_spi_receiver
//
// Reads one 16-bit frame from a PmodALS ambient light sensor (ADC081S021
// style SPI output) for each accepted conversion request. The frame carries
// three leading zeros, eight data bits and trailing zeros; the 8-bit light
// sample is extracted from bits [11:4] and any nonzero pad bit is reported
// as a frame error.
//
// Frame timing, in clk cycles:
//   LEAD  : CLK_DIV cycles with cs low and sck high
//   SHIFT : 32 half-phases of CLK_DIV cycles, first half-phase low
//   TRAIL : QUIET cycles with cs high before a new request is taken
//
// Parameters
//   CLK_DIV  clk cycles per SCK half-period (1..255)
//   QUIET    clk cycles cs stays high after a frame (1..255)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, ignored while busy
//   busy       frame in progress, including the quiet time
//   valid      one-cycle pulse when value/frame_err update
//   value      last received light sample
//   frame_err  last frame had nonzero pad bits
//   cs         chip select to the sensor, active low
//   sck        SPI clock to the sensor, idle high
//   sdo        serial data from the sensor
// -----------------------------------------------------------------------------
module pmod_als_spi_receiver #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned QUIET   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       valid,
    output logic [7:0] value,
    output logic       frame_err,
    output logic       cs,
    output logic       sck,
    input  logic       sdo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    // Terminal counts; counters are 8 bits so every legal parameter fits
    // without wrapping inside a frame.
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);
    localparam logic [7:0] PHASE_LAST = 8'd31;

    state_t      state_r;
    logic [7:0]  div_r;
    logic [7:0]  phase_r;
    logic [15:0] shift_r;
    logic        busy_r;
    logic        valid_r;
    logic [7:0]  value_r;
    logic        frame_err_r;
    logic        cs_r;
    logic        sck_r;

    // Pad bits are the four MSBs and four LSBs of the received word.
    function automatic logic pad_error(input logic [15:0] word);
        return (|word[15:12]) | (|word[3:0]);
    endfunction

    // Frame sequencer: owns every output register so nothing combinational
    // reaches a port from sdo or start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_r       <= 8'd0;
            phase_r     <= 8'd0;
            shift_r     <= 16'd0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            value_r     <= 8'h00;
            frame_err_r <= 1'b0;
            cs_r        <= 1'b1;
            sck_r       <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LEAD;
                        cs_r    <= 1'b0;
                        sck_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        div_r   <= 8'd0;
                        phase_r <= 8'd0;
                        shift_r <= 16'd0;
                    end else begin
                        cs_r   <= 1'b1;
                        sck_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end

                ST_LEAD: begin
                    if (div_r == DIV_LAST) begin
                        div_r   <= 8'd0;
                        sck_r   <= 1'b0;
                        state_r <= ST_SHIFT;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_SHIFT: begin
                    if (div_r == DIV_LAST) begin
                        div_r <= 8'd0;
                        if (phase_r == PHASE_LAST) begin
                            // Last half-phase is high already, so sck holds
                            // while cs rises.
                            cs_r        <= 1'b1;
                            valid_r     <= 1'b1;
                            value_r     <= shift_r[11:4];
                            frame_err_r <= pad_error(shift_r);
                            state_r     <= ST_TRAIL;
                        end else begin
                            phase_r <= phase_r + 8'd1;
                            sck_r   <= ~sck_r;
                            // Rising sck edge: sdo has been stable since the
                            // previous falling edge, sample it directly.
                            if (!sck_r) begin
                                shift_r <= {shift_r[14:0], sdo};
                            end else begin
                                shift_r <= shift_r;
                            end
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                ST_TRAIL: begin
                    if (div_r == QUIET_LAST) begin
                        div_r   <= 8'd0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    div_r   <= 8'd0;
                    phase_r <= 8'd0;
                    busy_r  <= 1'b0;
                    cs_r    <= 1'b1;
                    sck_r   <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign valid     = valid_r;
    assign value     = value_r;
    assign frame_err = frame_err_r;
    assign cs        = cs_r;
    assign sck       = sck_r;

endmodule

// File: tb/tb_pmod_als_spi_receiver.sv
`timescale 1ns/1ps
// Testbench for pmod_als_spi_receiver: sensor stub, scoreboard of expected
// samples, and a bus monitor that checks SPI framing and output timing.
module tb_pmod_als_spi_receiver;

    localparam int CLK_DIV = 4;
    localparam int QUIET   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sdo = 1'b0;
    logic       busy, valid, frame_err, cs, sck;
    logic [7:0] value;

    pmod_als_spi_receiver #(.CLK_DIV(CLK_DIV), .QUIET(QUIET)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .valid(valid),
        .value(value), .frame_err(frame_err), .cs(cs), .sck(sck), .sdo(sdo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: sensor word -> expected sample and pad error.
    typedef struct {
        logic [7:0] v;
        logic       e;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t model(input logic [15:0] w, input bit force_one);
        exp_t r;
        logic [15:0] word;
        word = force_one ? 16'hFFFF : w;
        r.v = word[11:4];
        r.e = (word[15:12] != 4'd0) || (word[3:0] != 4'd0);
        return r;
    endfunction

    // Sensor stub: drives the next bit MSB-first on every falling sck edge.
    logic [15:0] stub_word = 16'h0AB0;
    bit          force_one = 1'b0;
    int          idx = 15;
    always @(negedge cs) idx = 15;
    always @(negedge sck) begin
        if (cs === 1'b0) begin
            sdo = force_one ? 1'b1 : stub_word[idx];
            idx--;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state.
    int  cs_fall_cyc = 0, cs_rise_cyc = 0, last_fall = 0;
    int  falls = 0, per_bad = 0, viol = 0, valid_count = 0;
    int  b2b_start_cyc = 0;
    bit  in_frame = 1'b0, b2b = 1'b0;
    logic prev_cs = 1'b1, prev_sck = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sck  = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (cs === 1'b1 && sck !== 1'b1) viol++;
            if (prev_cs && !cs) begin
                in_frame    = 1'b1;
                cs_fall_cyc = cyc;
                falls       = 0;
                per_bad     = 0;
                if (b2b && cs_rise_cyc > b2b_start_cyc)
                    check("cs_high_gap", cyc - cs_rise_cyc, QUIET + 1);
            end
            if (in_frame && prev_sck && !sck) begin
                if (falls == 0) check("first_sck_fall", cyc - cs_fall_cyc, CLK_DIV);
                else if (cyc - last_fall != 2 * CLK_DIV) per_bad++;
                falls++;
                last_fall = cyc;
            end
            if (in_frame && !prev_cs && cs) begin
                in_frame = 1'b0;
                check("sck_falls", falls, 16);
                check("sck_period", per_bad, 0);
                check("cs_low_len", cyc - cs_fall_cyc, 33 * CLK_DIV);
                cs_rise_cyc = cyc;
            end
            if (valid === 1'b1) begin
                valid_count++;
                check("valid_timing", cyc - cs_fall_cyc, 33 * CLK_DIV);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got value %0h, expected no valid", value);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("value", int'(value), int'(e.v));
                    check("frame_err", int'(frame_err), int'(e.e));
                end
            end
            if (prev_busy && !busy)
                check("busy_fall", cyc - cs_fall_cyc, 33 * CLK_DIV + QUIET);
            prev_cs   = cs;
            prev_sck  = sck;
            prev_busy = busy;
        end
    end

    int expected_valids = 0;
    int req_cyc = 0;

    task automatic issue(input logic [15:0] w, input bit f);
        stub_word = w;
        force_one = f;
        @(negedge clk);
        start = 1'b1;
        req_cyc = cyc;
        sb.push_back(model(w, f));
        expected_valids++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input bit f);
        issue(w, f);
        repeat (150) @(negedge clk);
        check("cs_fall_latency", cs_fall_cyc - req_cyc, 1);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [15:0] w;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cs", int'(cs), 1);
        check("rst_sck", int'(sck), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_value", int'(value), 0);
        check("rst_err", int'(frame_err), 0);
        rst_n = 1'b1;

        // Nominal frame, first start right after reset.
        run_frame(16'h0AB0, 1'b0);

        // Start while busy is ignored.
        issue(16'h0AB0, 1'b0);
        repeat (48) @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        check("drain_busy_start", sb.size(), 0);

        // Pad error, then recovery.
        run_frame(16'h0AB0, 1'b1);
        run_frame(16'h0AB0, 1'b0);

        // Randomized sensor words, half with clean pads.
        repeat (8) begin
            w = 16'($urandom);
            if ($urandom_range(1, 0) == 1) w = {4'h0, w[11:4], 4'h0};
            run_frame(w, 1'b0);
        end

        // Back-to-back with start held high.
        stub_word = 16'h0AB0;
        force_one = 1'b0;
        b2b = 1'b1;
        b2b_start_cyc = cyc;
        @(negedge clk);
        start = 1'b1;
        repeat (3) begin
            sb.push_back(model(16'h0AB0, 1'b0));
            expected_valids++;
        end
        repeat (283) @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        check("drain_b2b", sb.size(), 0);
        b2b = 1'b0;

        // Reset mid-frame.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("value_after_rst", int'(value), 0);
        issue(16'h0AB0, 1'b0);
        repeat (58) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", int'(cs), 1);
        check("async_rst_sck", int'(sck), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_value", int'(value), 0);
        sb.delete();
        expected_valids--;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("value_held_rst", int'(value), 0);
        run_frame(16'h0AB0, 1'b0);

        check("sck_high_when_cs_high", viol, 0);
        check("valid_count", valid_count, expected_valids);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
